// File: rtl/param_fifo_sram.sv
// Parametrised single-clock FIFO on a register-array SRAM. It has a non-power-of-two depth,
// an occupancy count, threshold flags, sticky overflow/underflow flags and a selectable FWFT read mode.
module param_fifo_sram #(
  parameter int unsigned BITS       = 12,
  parameter int unsigned WORD_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AFULL_TH   = 6,
  parameter int unsigned AEMPTY_TH  = 2,
  parameter bit          FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic                  read,
  input  logic [BITS-1:0]       data_in,
  input  logic                  clr_flags,
  output logic [BITS-1:0]       data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(WORD_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DepthCnt = (ADDR_WIDTH + 1)'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH:0]   AfullCnt = (ADDR_WIDTH + 1)'(AFULL_TH);
  localparam logic [ADDR_WIDTH:0]   AemptyCnt = (ADDR_WIDTH + 1)'(AEMPTY_TH);

  logic [BITS-1:0]       mem [WORD_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [BITS-1:0]       dout_q;
  logic                  valid_q;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  ovf_q, unf_q;
  logic                  rd_acc, wr_acc;

  assign rd_acc = read & ~empty_q;
  // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
  assign wr_acc = write & (~full_q | rd_acc);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_acc && !rd_acc) begin
      cnt_d = cnt_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Memory has no reset; the content is invalidated through the pointers and the count.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= (AFULL_TH == 0);
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == LastAddr) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == LastAddr) ? '0 : rd_ptr + 1'b1;
        dout_q <= mem[rd_ptr];
      end
      valid_q  <= rd_acc;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == DepthCnt);
      empty_q  <= (cnt_d == '0);
      afull_q  <= (cnt_d >= AfullCnt);
      aempty_q <= (cnt_d <= AemptyCnt);
      ovf_q    <= (write & ~wr_acc) | (ovf_q & ~clr_flags);
      unf_q    <= (read & ~rd_acc) | (unf_q & ~clr_flags);
    end
  end

  // In fall-through mode the head word is presented directly; when empty, the last popped word is held.
  assign data_out     = (FWFT && !empty_q) ? mem[rd_ptr] : dout_q;
  assign data_valid   = FWFT ? ~empty_q : valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_param_fifo_sram.sv
// Scoreboard bench: two FIFO instances (depth 8 registered read, depth 6 fall-through) driven
// by the same stimulus and compared against queue-based reference models.
module tb_param_fifo_sram;

  localparam int DA = 8, AFA = 6, AEA = 2;
  localparam int DB = 6, AFB = 6, AEB = 0;

  logic clk = 1'b0;
  logic rst = 1'b1, write = 1'b0, read = 1'b0, clr_flags = 1'b0;
  logic [11:0] data_in = '0;

  logic [11:0] dout_a, dout_b;
  logic dv_a, full_a, empty_a, af_a, ae_a, ov_a, un_a;
  logic dv_b, full_b, empty_b, af_b, ae_b, ov_b, un_b;
  logic [3:0] cnt_a, cnt_b;

  param_fifo_sram #(.BITS(12), .WORD_DEPTH(DA), .ADDR_WIDTH(3), .AFULL_TH(AFA),
                    .AEMPTY_TH(AEA), .FWFT(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .write(write), .read(read), .data_in(data_in),
    .clr_flags(clr_flags), .data_out(dout_a), .data_valid(dv_a), .full(full_a),
    .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a), .count(cnt_a),
    .overflow(ov_a), .underflow(un_a)
  );

  param_fifo_sram #(.BITS(12), .WORD_DEPTH(DB), .ADDR_WIDTH(3), .AFULL_TH(AFB),
                    .AEMPTY_TH(AEB), .FWFT(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .write(write), .read(read), .data_in(data_in),
    .clr_flags(clr_flags), .data_out(dout_b), .data_valid(dv_b), .full(full_b),
    .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b), .count(cnt_b),
    .overflow(ov_b), .underflow(un_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        rd_a;
    logic [3:0]  cnt_a;
    logic        ov_a, un_a;
    logic [3:0]  cnt_b;
    logic        ov_b, un_b;
    logic [11:0] head_b;
  } rec_t;

  rec_t        st_q[$];
  logic [11:0] da_q[$];
  logic [11:0] qa[$], qb[$];
  bit          ova, una, ovb, unb;
  int          n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle and advance both reference models to the state after the next edge.
  task automatic cycle(input bit rs, input bit w, input bit r, input logic [11:0] d,
                       input bit c);
    rec_t rec;
    bit ra, wa, rb, wb;
    @(negedge clk);
    rst = rs; write = w; read = r; data_in = d; clr_flags = c;
    rec = '0;
    rec.rst = rs;
    if (rs) begin
      qa.delete(); qb.delete();
      ova = 0; una = 0; ovb = 0; unb = 0;
    end else begin
      ra = r && qa.size() > 0;
      wa = w && (qa.size() < DA || ra);
      if (ra) begin
        da_q.push_back(qa.pop_front());
        rec.rd_a = 1'b1;
      end
      if (wa) qa.push_back(d);
      ova = (w && !wa) || (ova && !c);
      una = (r && !ra) || (una && !c);
      rb = r && qb.size() > 0;
      wb = w && (qb.size() < DB || rb);
      if (rb) void'(qb.pop_front());
      if (wb) qb.push_back(d);
      ovb = (w && !wb) || (ovb && !c);
      unb = (r && !rb) || (unb && !c);
    end
    rec.cnt_a = 4'(qa.size());
    rec.ov_a = ova; rec.un_a = una;
    rec.cnt_b = 4'(qb.size());
    rec.ov_b = ovb; rec.un_b = unb;
    rec.head_b = (qb.size() > 0) ? qb[0] : 12'h000;
    st_q.push_back(rec);
  endtask

  // Monitor: pops one expected status record per edge and read data whenever the DUT presents it.
  initial begin
    rec_t r;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        r = st_q.pop_front();
        chk("count_a", cnt_a, r.cnt_a);
        chk("full_a", full_a, r.cnt_a == DA);
        chk("empty_a", empty_a, r.cnt_a == 0);
        chk("afull_a", af_a, r.cnt_a >= AFA);
        chk("aempty_a", ae_a, r.cnt_a <= AEA);
        chk("ovf_a", ov_a, r.ov_a);
        chk("unf_a", un_a, r.un_a);
        chk("valid_a", dv_a, r.rd_a);
        if (dv_a) begin
          if (da_q.size() == 0) chk("data_a_unexpected", 1, 0);
          else chk("data_a", dout_a, da_q.pop_front());
        end
        if (r.rst) chk("data_a_reset", dout_a, 0);
        chk("count_b", cnt_b, r.cnt_b);
        chk("full_b", full_b, r.cnt_b == DB);
        chk("empty_b", empty_b, r.cnt_b == 0);
        chk("afull_b", af_b, r.cnt_b >= AFB);
        chk("aempty_b", ae_b, r.cnt_b <= AEB);
        chk("ovf_b", ov_b, r.ov_b);
        chk("unf_b", un_b, r.un_b);
        chk("valid_b", dv_b, r.cnt_b != 0);
        if (r.cnt_b != 0) chk("data_b", dout_b, r.head_b);
      end
    end
  end

  initial begin
    int wp, rp;
    cycle(1, 0, 0, 12'h000, 0);
    cycle(1, 0, 0, 12'h000, 0);
    for (int i = 1; i <= 8; i++) cycle(0, 1, 0, 12'(i), 0);
    cycle(0, 1, 0, 12'h009, 0);           // rejected write: overflow
    cycle(0, 1, 0, 12'h0aa, 1);           // clear loses to a new rejection
    cycle(0, 0, 0, 12'h000, 1);
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, 12'h000, 0);
    cycle(0, 1, 1, 12'h0e0, 0);           // empty: write only, read rejected
    cycle(0, 0, 0, 12'h000, 0);
    cycle(0, 0, 1, 12'h000, 0);
    cycle(0, 0, 0, 12'h000, 1);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 12'h010 + 12'(i), 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 12'h020 + 12'(i), 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 12'h000, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 12'h030 + 12'(i), 0);
    cycle(1, 1, 0, 12'h3ff, 0);           // reset beats the write
    cycle(0, 0, 0, 12'h000, 0);
    for (int ph = 0; ph < 4; ph++) begin
      wp = (ph == 0) ? 75 : (ph == 1) ? 30 : 55;
      rp = (ph == 0) ? 30 : (ph == 1) ? 75 : 55;
      for (int i = 0; i < 150; i++) begin
        cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < wp,
              $urandom_range(0, 99) < rp, 12'($urandom), $urandom_range(0, 19) == 0);
      end
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 12'h000, 0);
    @(posedge clk);
    #3;
    chk("records_drained", st_q.size(), 0);
    chk("read_data_drained", da_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
